// File: rtl/celery_pkg.sv
// Shared rasterizer-pipeline types: vertices, setup results and dispatcher FSM states.
package celery_pkg;

    typedef struct packed {
        logic signed [15:0] x;
        logic signed [15:0] y;
        logic        [15:0] z;
    } vertex_t;

    typedef struct packed {
        logic               valid;
        logic signed [31:0] area;
        logic signed [15:0] min_x;
        logic signed [15:0] max_x;
        logic signed [15:0] min_y;
        logic signed [15:0] max_y;
    } triangle_setup_t;

    typedef enum logic {
        SU_IDLE,
        SU_WAIT
    } dispatch_su_state_t;

    typedef enum logic {
        RA_IDLE,
        RA_RUN
    } dispatch_ra_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count and synchronous clear; head is read combinationally.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;

    // Explicit wrap so non-power-of-two depths work too.
    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= bump(wr_ptr);
            if (pop)  rd_ptr <= bump(rd_ptr);
            if (push && !pop)      count <= count + CW'(1);
            else if (pop && !push) count <= count - CW'(1);
        end
    end

    // NOTE: storage is deliberately not reset; count and pointers decide what is valid.
    always_ff @(posedge clk) begin
        if (push && !clear) mem[wr_ptr] <= wdata;
    end

    assign rdata = mem[rd_ptr];

endmodule

// File: rtl/tri_dispatch.sv
// Triangle dispatcher: queues vertex triples and overlaps setup of triangle N+1 with raster of N.
// Statistics counters are built only when CELERY_TRI_STATS_EN is defined.
module tri_dispatch
    import celery_pkg::*;
#(
    parameter int FIFO_DEPTH  = 4,
    parameter int SETUP_SLOTS = 2,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  vertex_t              v0,
    input  vertex_t              v1,
    input  vertex_t              v2,
    input  logic                 tri_valid,
    output logic                 tri_ready,
    output vertex_t              setup_v0,
    output vertex_t              setup_v1,
    output vertex_t              setup_v2,
    output logic                 setup_start,
    input  triangle_setup_t      setup_result,
    input  logic                 setup_done,
    output triangle_setup_t      rast_tri,
    output logic                 rast_start,
    input  logic                 rast_done,
    input  logic                 flush,
    output logic                 busy,
    input  logic                 stat_clear,
    output logic [CNT_WIDTH-1:0] stat_accepted,
    output logic [CNT_WIDTH-1:0] stat_culled,
    output logic [CNT_WIDTH-1:0] stat_rasterized
);
    localparam int FCW = $clog2(FIFO_DEPTH + 1);
    localparam int SCW = $clog2(SETUP_SLOTS + 1);
    localparam int VW  = 3 * $bits(vertex_t);
    localparam int TW  = $bits(triangle_setup_t);

    dispatch_su_state_t su_state, su_next;
    dispatch_ra_state_t ra_state, ra_next;
    logic               su_discard;

    logic [FCW-1:0]  fifo_count;
    logic [SCW-1:0]  slot_count;
    logic [VW-1:0]   fifo_head;
    vertex_t         head_v0, head_v1, head_v2;
    triangle_setup_t slot_head;

    logic fifo_push, fifo_empty, slot_empty, slot_full;
    logic su_issue, su_cull, slot_push, slot_pop, ra_finish;

    assign fifo_empty = (fifo_count == '0);
    assign slot_empty = (slot_count == '0);
    assign slot_full  = (slot_count == SCW'(SETUP_SLOTS));
    assign tri_ready  = (fifo_count != FCW'(FIFO_DEPTH)) && !flush;
    assign fifo_push  = tri_valid && tri_ready;
    assign {head_v0, head_v1, head_v2} = fifo_head;

    sync_fifo #(.WIDTH(VW), .DEPTH(FIFO_DEPTH)) u_tri_fifo (
        .clk   (clk),
        .rst   (rst),
        .clear (flush),
        .push  (fifo_push),
        .wdata ({v0, v1, v2}),
        .pop   (su_issue),
        .rdata (fifo_head),
        .count (fifo_count)
    );

    sync_fifo #(.WIDTH(TW), .DEPTH(SETUP_SLOTS)) u_slot_buf (
        .clk   (clk),
        .rst   (rst),
        .clear (flush),
        .push  (slot_push),
        .wdata (setup_result),
        .pop   (slot_pop),
        .rdata (slot_head),
        .count (slot_count)
    );

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        su_next   = su_state;
        ra_next   = ra_state;
        su_issue  = 1'b0;
        su_cull   = 1'b0;
        slot_push = 1'b0;
        slot_pop  = 1'b0;
        ra_finish = 1'b0;

        case (su_state)
            SU_IDLE: begin
                if (!fifo_empty && !slot_full && !flush) begin
                    su_issue = 1'b1;
                    su_next  = SU_WAIT;
                end
            end
            SU_WAIT: begin
                if (setup_done) begin
                    su_next = SU_IDLE;
                    // A setup started before a flush finishes but its result is dropped.
                    if (!su_discard && !flush) begin
                        slot_push = setup_result.valid;
                        su_cull   = !setup_result.valid;
                    end
                end
            end
            default: su_next = SU_IDLE;
        endcase

        case (ra_state)
            RA_IDLE: begin
                if (!slot_empty && !flush) begin
                    slot_pop = 1'b1;
                    ra_next  = RA_RUN;
                end
            end
            RA_RUN: begin
                if (rast_done) begin
                    ra_finish = 1'b1;
                    ra_next   = RA_IDLE;
                end
            end
            default: ra_next = RA_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            su_state   <= SU_IDLE;
            ra_state   <= RA_IDLE;
            su_discard <= 1'b0;
        end else begin
            su_state   <= su_next;
            ra_state   <= ra_next;
            su_discard <= (su_next == SU_WAIT) && (su_discard || flush);
        end
    end

    // Start pulses leave together with the registered operands they qualify.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            setup_v0    <= '0;
            setup_v1    <= '0;
            setup_v2    <= '0;
            setup_start <= 1'b0;
            rast_tri    <= '0;
            rast_start  <= 1'b0;
        end else begin
            setup_start <= su_issue;
            rast_start  <= slot_pop;
            if (su_issue) begin
                setup_v0 <= head_v0;
                setup_v1 <= head_v1;
                setup_v2 <= head_v2;
            end
            if (slot_pop) rast_tri <= slot_head;
        end
    end

    assign busy = !fifo_empty || (su_state == SU_WAIT) || !slot_empty || (ra_state == RA_RUN);

`ifdef CELERY_TRI_STATS_EN
    logic [CNT_WIDTH-1:0] acc_q, cull_q, rast_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q  <= '0;
            cull_q <= '0;
            rast_q <= '0;
        end else if (stat_clear) begin
            acc_q  <= '0;
            cull_q <= '0;
            rast_q <= '0;
        end else begin
            if (fifo_push && acc_q != '1) acc_q  <= acc_q + CNT_WIDTH'(1);
            if (su_cull && cull_q != '1)  cull_q <= cull_q + CNT_WIDTH'(1);
            if (ra_finish && rast_q != '1) rast_q <= rast_q + CNT_WIDTH'(1);
        end
    end

    assign stat_accepted   = acc_q;
    assign stat_culled     = cull_q;
    assign stat_rasterized = rast_q;
`else
    logic unused_stat;
    assign unused_stat     = stat_clear ^ su_cull ^ ra_finish;
    assign stat_accepted   = '0;
    assign stat_culled     = '0;
    assign stat_rasterized = '0;
`endif

endmodule

// File: tb/tb_tri_dispatch.sv
// Directed bench for tri_dispatch with stub setup/raster units and hand-computed expectations.
module tb_tri_dispatch;
    import celery_pkg::*;

    localparam int FIFO_DEPTH  = 4;
    localparam int SETUP_SLOTS = 2;
    localparam int CNT_WIDTH   = 32;
`ifdef CELERY_TRI_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    vertex_t v0, v1, v2;
    logic tri_valid, tri_ready;
    vertex_t setup_v0, setup_v1, setup_v2;
    logic setup_start, setup_done;
    triangle_setup_t setup_result, rast_tri;
    logic rast_start, rast_done, flush, busy, stat_clear;
    logic [CNT_WIDTH-1:0] stat_accepted, stat_culled, stat_rasterized;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    bit manual = 1'b0;
    bit ra_hold = 1'b0;
    int su_lat = 4;
    int ra_lat = 20;
    int su_cnt = 0;
    int ra_cnt = 0;
    logic auto_su_done = 1'b0;
    logic auto_ra_done = 1'b0;
    logic man_su_done = 1'b0;
    logic man_ra_done = 1'b0;
    triangle_setup_t auto_res = '0;
    triangle_setup_t man_res = '0;

    triangle_setup_t rast_log[$];
    int su_start_cyc[$];
    int rast_start_cyc[$];
    int rast_done_cyc[$];
    int bp_k;

    assign setup_done   = manual ? man_su_done : auto_su_done;
    assign setup_result = manual ? man_res : auto_res;
    assign rast_done    = manual ? man_ra_done : auto_ra_done;

    tri_dispatch #(
        .FIFO_DEPTH(FIFO_DEPTH), .SETUP_SLOTS(SETUP_SLOTS), .CNT_WIDTH(CNT_WIDTH)
    ) dut (
        .clk(clk), .rst(rst), .v0(v0), .v1(v1), .v2(v2),
        .tri_valid(tri_valid), .tri_ready(tri_ready),
        .setup_v0(setup_v0), .setup_v1(setup_v1), .setup_v2(setup_v2),
        .setup_start(setup_start), .setup_result(setup_result), .setup_done(setup_done),
        .rast_tri(rast_tri), .rast_start(rast_start), .rast_done(rast_done),
        .flush(flush), .busy(busy), .stat_clear(stat_clear),
        .stat_accepted(stat_accepted), .stat_culled(stat_culled), .stat_rasterized(stat_rasterized)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic vertex_t vx(input int x, input int y, input int z);
        vertex_t v;
        v.x = 16'(x);
        v.y = 16'(y);
        v.z = 16'(z);
        return v;
    endfunction

    // Stand-in for triangle_setup: signed doubled area and bounding box; zero area is culled.
    function automatic triangle_setup_t model(input vertex_t a, input vertex_t b, input vertex_t c);
        triangle_setup_t r;
        int ax, ay, bx, by, cx, cy, ar, mn, mx;
        ax = a.x; ay = a.y; bx = b.x; by = b.y; cx = c.x; cy = c.y;
        ar = (bx - ax) * (cy - ay) - (cx - ax) * (by - ay);
        r.valid = (ar != 0);
        r.area  = ar;
        mn = (ax < bx) ? ax : bx; mn = (cx < mn) ? cx : mn;
        mx = (ax > bx) ? ax : bx; mx = (cx > mx) ? cx : mx;
        r.min_x = 16'(mn); r.max_x = 16'(mx);
        mn = (ay < by) ? ay : by; mn = (cy < mn) ? cy : mn;
        mx = (ay > by) ? ay : by; mx = (cy > mx) ? cy : mx;
        r.min_y = 16'(mn); r.max_y = 16'(mx);
        return r;
    endfunction

    task automatic bp_tri(input int i, output vertex_t a, output vertex_t b, output vertex_t c);
        a = vx(i * 3, 0, i + 1);
        b = vx(i * 3 + 5, 0, 0);
        c = vx(i * 3, 7, 0);
    endtask

    // Stub setup unit: done su_lat cycles after the start pulse.
    always @(negedge clk) begin
        auto_su_done = 1'b0;
        if (rst || manual) su_cnt = 0;
        else if (setup_start) su_cnt = su_lat;
        else if (su_cnt > 0) begin
            su_cnt--;
            if (su_cnt == 0) begin
                auto_su_done = 1'b1;
                auto_res = model(setup_v0, setup_v1, setup_v2);
            end
        end
    end

    // Stub rasterizer: done ra_lat unheld cycles after the start pulse.
    always @(negedge clk) begin
        auto_ra_done = 1'b0;
        if (rst || manual) ra_cnt = 0;
        else if (rast_start) ra_cnt = ra_lat;
        else if (ra_cnt > 0 && !ra_hold) begin
            ra_cnt--;
            if (ra_cnt == 0) auto_ra_done = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (setup_start) su_start_cyc.push_back(cyc);
            if (rast_start) begin
                rast_log.push_back(rast_tri);
                rast_start_cyc.push_back(cyc);
            end
        end
    end

    always @(posedge clk) begin
        if (!rst && rast_done) rast_done_cyc.push_back(cyc);
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_logs();
        rast_log.delete();
        su_start_cyc.delete();
        rast_start_cyc.delete();
        rast_done_cyc.delete();
    endtask

    task automatic clear_stats();
        stat_clear = 1'b1;
        @(negedge clk);
        stat_clear = 1'b0;
    endtask

    task automatic send(input vertex_t a, input vertex_t b, input vertex_t c);
        bit done = 1'b0;
        v0 = a; v1 = b; v2 = c;
        tri_valid = 1'b1;
        for (int i = 0; i < 100 && !done; i++) begin
            #1;
            done = tri_ready;
            @(negedge clk);
        end
        tri_valid = 1'b0;
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL send_accept: tri_ready=0 for 100 cycles, required 1");
        end
    endtask

    task automatic wait_idle(input int limit, input string name);
        bit idle = 1'b0;
        for (int i = 0; i < limit && !idle; i++) begin
            if (!busy) idle = 1'b1;
            else @(negedge clk);
        end
        checks++;
        if (!idle) begin
            errors++;
            $display("FAIL %s_idle: busy=1 after %0d cycles, required 0", name, limit);
        end
    endtask

    task automatic wait_setup_start();
        bit seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            if (setup_start) seen = 1'b1;
            else @(negedge clk);
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL setup_start_wait: no setup_start in 30 cycles");
        end
        @(negedge clk);
    endtask

    task automatic pulse_su(input triangle_setup_t r);
        man_res = r;
        man_su_done = 1'b1;
        @(negedge clk);
        man_su_done = 1'b0;
    endtask

    task automatic pulse_ra();
        man_ra_done = 1'b1;
        @(negedge clk);
        man_ra_done = 1'b0;
    endtask

    task automatic offer_stream(input int cycles);
        logic acc;
        vertex_t a, b, c;
        for (int n = 0; n < cycles && bp_k < 10; n++) begin
            bp_tri(bp_k, a, b, c);
            v0 = a; v1 = b; v2 = c;
            tri_valid = 1'b1;
            #1;
            acc = tri_ready;
            @(negedge clk);
            if (acc) bp_k++;
        end
        tri_valid = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++; if (tri_ready !== 1'b1) begin errors++; $display("FAIL reset_tri_ready: got %b want 1", tri_ready); end
        checks++; if (setup_start !== 1'b0) begin errors++; $display("FAIL reset_setup_start: got %b want 0", setup_start); end
        checks++; if (rast_start !== 1'b0) begin errors++; $display("FAIL reset_rast_start: got %b want 0", rast_start); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if ({setup_v0, setup_v1, setup_v2} !== '0) begin errors++; $display("FAIL reset_setup_v: got %h want 0", {setup_v0, setup_v1, setup_v2}); end
        checks++; if (rast_tri !== '0) begin errors++; $display("FAIL reset_rast_tri: got %h want 0", rast_tri); end
        checks++; if ({stat_accepted, stat_culled, stat_rasterized} !== '0) begin errors++; $display("FAIL reset_stats: got %0d/%0d/%0d want 0", stat_accepted, stat_culled, stat_rasterized); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (tri_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL post_reset: tri_ready=%b busy=%b want 1/0", tri_ready, busy); end
    endtask

    task automatic test_overlap();
        vertex_t t [3][3];
        t[0] = '{vx(0, 0, 1), vx(10, 0, 1), vx(0, 10, 1)};
        t[1] = '{vx(5, 5, 2), vx(20, 5, 2), vx(5, 30, 2)};
        t[2] = '{vx(-4, -4, 3), vx(8, -4, 3), vx(-4, 6, 3)};
        manual = 1'b0; su_lat = 4; ra_lat = 20; ra_hold = 1'b0;
        clear_stats();
        clear_logs();
        for (int i = 0; i < 3; i++) send(t[i][0], t[i][1], t[i][2]);
        wait_idle(400, "overlap");
        checks++;
        if (rast_log.size() != 3) begin
            errors++; $display("FAIL overlap_count: got %0d rast_start pulses want 3", rast_log.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (rast_log[i] !== model(t[i][0], t[i][1], t[i][2])) begin
                    errors++; $display("FAIL overlap_tri%0d: got %h want %h", i, rast_log[i], model(t[i][0], t[i][1], t[i][2]));
                end
            end
        end
        checks++;
        if (su_start_cyc.size() < 2 || rast_start_cyc.size() < 1 || rast_done_cyc.size() < 1 ||
            su_start_cyc[1] < rast_start_cyc[0] || su_start_cyc[1] >= rast_done_cyc[0]) begin
            errors++; $display("FAIL overlap_timing: second setup_start not inside first raster run");
        end
        checks++;
        if (stat_rasterized !== CNT_WIDTH'(STATS ? 3 : 0)) begin
            errors++; $display("FAIL overlap_stat_rasterized: got %0d want %0d", stat_rasterized, STATS ? 3 : 0);
        end
    endtask

    task automatic test_cull();
        vertex_t a [3], d [3], c [3];
        a = '{vx(1, 1, 4), vx(9, 1, 4), vx(1, 5, 4)};
        d = '{vx(0, 0, 0), vx(1, 1, 0), vx(2, 2, 0)};
        c = '{vx(2, 3, 5), vx(12, 3, 5), vx(2, -7, 5)};
        manual = 1'b0; su_lat = 3; ra_lat = 5;
        clear_stats();
        clear_logs();
        send(a[0], a[1], a[2]);
        send(d[0], d[1], d[2]);
        send(c[0], c[1], c[2]);
        wait_idle(300, "cull");
        checks++;
        if (rast_log.size() != 2) begin
            errors++; $display("FAIL cull_count: got %0d rast_start pulses want 2", rast_log.size());
        end else begin
            checks++; if (rast_log[0] !== model(a[0], a[1], a[2])) begin errors++; $display("FAIL cull_tri1: got %h", rast_log[0]); end
            checks++; if (rast_log[1] !== model(c[0], c[1], c[2])) begin errors++; $display("FAIL cull_tri3: got %h", rast_log[1]); end
        end
        checks++;
        if (stat_culled !== CNT_WIDTH'(STATS ? 1 : 0)) begin
            errors++; $display("FAIL cull_stat_culled: got %0d want %0d", stat_culled, STATS ? 1 : 0);
        end
    endtask

    task automatic test_backpressure();
        int bad = 0;
        vertex_t a, b, c;
        manual = 1'b0; su_lat = 2; ra_lat = 3; ra_hold = 1'b1;
        clear_stats();
        clear_logs();
        bp_k = 0;
        offer_stream(60);
        checks++; if (bp_k != 7) begin errors++; $display("FAIL bp_accepted_held: got %0d want 7", bp_k); end
        checks++; if (tri_ready !== 1'b0) begin errors++; $display("FAIL bp_tri_ready_low: got %b want 0", tri_ready); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL bp_busy: got %b want 1", busy); end
        ra_hold = 1'b0;
        offer_stream(300);
        wait_idle(400, "bp");
        checks++;
        if (rast_log.size() != 10) begin
            errors++; $display("FAIL bp_count: got %0d rasterized want 10", rast_log.size());
        end else begin
            for (int i = 0; i < 10; i++) begin
                bp_tri(i, a, b, c);
                if (rast_log[i] !== model(a, b, c)) bad++;
            end
            checks++;
            if (bad != 0) begin errors++; $display("FAIL bp_order: %0d of 10 triangles wrong or out of order", bad); end
        end
        checks++;
        if (stat_accepted !== CNT_WIDTH'(STATS ? 10 : 0)) begin
            errors++; $display("FAIL bp_stat_accepted: got %0d want %0d", stat_accepted, STATS ? 10 : 0);
        end
    endtask

    task automatic test_flush();
        vertex_t t [5][3];
        triangle_setup_t r;
        for (int i = 0; i < 5; i++) t[i] = '{vx(i, 0, 9), vx(i + 4, 0, 9), vx(i, 6, 9)};
        manual = 1'b1;
        clear_stats();
        clear_logs();
        send(t[0][0], t[0][1], t[0][2]);
        wait_setup_start();
        pulse_su(model(t[0][0], t[0][1], t[0][2]));
        send(t[1][0], t[1][1], t[1][2]);
        wait_setup_start();
        pulse_su(model(t[1][0], t[1][1], t[1][2]));
        send(t[2][0], t[2][1], t[2][2]);
        wait_setup_start();
        send(t[3][0], t[3][1], t[3][2]);
        send(t[4][0], t[4][1], t[4][2]);
        flush = 1'b1;
        #1;
        checks++; if (tri_ready !== 1'b0) begin errors++; $display("FAIL flush_tri_ready: got %b want 0", tri_ready); end
        @(negedge clk);
        flush = 1'b0;
        r = model(t[2][0], t[2][1], t[2][2]);
        r.valid = 1'b0;
        pulse_su(r);
        repeat (5) @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL flush_busy_run: got %b want 1", busy); end
        man_ra_done = 1'b1;
        #1;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL flush_busy_done_cycle: got %b want 1", busy); end
        @(negedge clk);
        man_ra_done = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_busy_drop: got %b want 0", busy); end
        repeat (10) @(negedge clk);
        checks++; if (rast_log.size() != 1) begin errors++; $display("FAIL flush_no_restart: got %0d rast_start pulses want 1", rast_log.size()); end
        checks++; if (stat_culled !== '0) begin errors++; $display("FAIL flush_discard_not_culled: got %0d want 0", stat_culled); end
        checks++;
        if (stat_rasterized !== CNT_WIDTH'(STATS ? 1 : 0)) begin
            errors++; $display("FAIL flush_stat_rasterized: got %0d want %0d", stat_rasterized, STATS ? 1 : 0);
        end
    endtask

    task automatic test_simultaneous();
        vertex_t t [3][3];
        t[0] = '{vx(0, 0, 7), vx(6, 0, 7), vx(0, 6, 7)};
        t[1] = '{vx(3, 3, 8), vx(9, 3, 8), vx(3, 11, 8)};
        t[2] = '{vx(-2, 0, 6), vx(4, 0, 6), vx(-2, -5, 6)};
        manual = 1'b1;
        clear_logs();
        send(t[0][0], t[0][1], t[0][2]);
        wait_setup_start();
        pulse_su(model(t[0][0], t[0][1], t[0][2]));
        send(t[1][0], t[1][1], t[1][2]);
        wait_setup_start();
        pulse_su(model(t[1][0], t[1][1], t[1][2]));
        send(t[2][0], t[2][1], t[2][2]);
        wait_setup_start();
        repeat (2) @(negedge clk);
        checks++; if (dut.slot_count !== 2'd1) begin errors++; $display("FAIL sim_pre_slot_count: got %0d want 1", dut.slot_count); end
        pulse_ra();
        man_res = model(t[2][0], t[2][1], t[2][2]);
        man_su_done = 1'b1;
        @(negedge clk);
        man_su_done = 1'b0;
        checks++; if (dut.slot_count !== 2'd1) begin errors++; $display("FAIL sim_slot_count: got %0d want 1", dut.slot_count); end
        checks++;
        if (rast_start !== 1'b1 || rast_tri !== model(t[1][0], t[1][1], t[1][2])) begin
            errors++; $display("FAIL sim_pop: rast_start=%b rast_tri=%h want 1 and triangle 2", rast_start, rast_tri);
        end
        repeat (2) @(negedge clk);
        pulse_ra();
        repeat (3) @(negedge clk);
        pulse_ra();
        wait_idle(20, "sim");
        checks++;
        if (rast_log.size() != 3 || rast_log[2] !== model(t[2][0], t[2][1], t[2][2])) begin
            errors++; $display("FAIL sim_third: got %0d rasterized, last not triangle 3", rast_log.size());
        end
    endtask

    task automatic test_reset_mid();
        manual = 1'b0; su_lat = 3; ra_lat = 10;
        send(vx(0, 0, 1), vx(10, 0, 1), vx(0, 10, 1));
        send(vx(1, 1, 2), vx(8, 1, 2), vx(1, 9, 2));
        send(vx(2, 2, 3), vx(9, 2, 3), vx(2, 8, 3));
        repeat (8) @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rstmid_busy_before: got %b want 1", busy); end
        rst = 1'b1;
        #1;
        checks++; if (busy !== 1'b0 || tri_ready !== 1'b1) begin errors++; $display("FAIL rstmid_handshake: busy=%b tri_ready=%b want 0/1", busy, tri_ready); end
        checks++; if (setup_start !== 1'b0 || rast_start !== 1'b0) begin errors++; $display("FAIL rstmid_starts: %b/%b want 0/0", setup_start, rast_start); end
        checks++; if ({setup_v0, setup_v1, setup_v2} !== '0) begin errors++; $display("FAIL rstmid_setup_v: got %h want 0", {setup_v0, setup_v1, setup_v2}); end
        checks++; if (rast_tri !== '0) begin errors++; $display("FAIL rstmid_rast_tri: got %h want 0", rast_tri); end
        checks++; if ({stat_accepted, stat_culled, stat_rasterized} !== '0) begin errors++; $display("FAIL rstmid_stats: got %0d/%0d/%0d want 0", stat_accepted, stat_culled, stat_rasterized); end
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_after: busy=%b want 0", busy); end
    endtask

    initial begin
        rst = 1'b1;
        v0 = '0; v1 = '0; v2 = '0;
        tri_valid = 1'b0;
        flush = 1'b0;
        stat_clear = 1'b0;
        test_reset();
        test_overlap();
        test_cull();
        test_backpressure();
        test_flush();
        test_simultaneous();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tri_dispatch.md
# tri_dispatch

Triangle dispatcher that replaces the single-triangle IDLE/SETUP/RASTERIZE controller in front of `triangle_setup` and `rasterizer`. It buffers incoming triangles in a parametrised FIFO and holds completed setups in a parametrised slot buffer. This lets setup of triangle N+1 overlap rasterization of triangle N. It culls degenerate triangles, supports a synchronous flush, and optionally keeps statistics counters.

## Interface
- `FIFO_DEPTH`, default 4: vertex-triple queue depth; a power of two, ≥2.
- `SETUP_SLOTS`, default 2: completed-setup buffer depth; ≥1.
- `CNT_WIDTH`, default 32: statistics counter width.
- `clk`, in, 1: clock.
- `rst`, in, 1: reset, asynchronous, active-high.
- `v0`, `v1`, `v2`, in, `vertex_t`: incoming triangle.
- `tri_valid`, in, 1; `tri_ready`, out, 1: input handshake.
- `setup_v0`, `setup_v1`, `setup_v2`, out, `vertex_t`: registered vertices to `triangle_setup`; held stable while setup is in flight.
- `setup_start`, out, 1: one-cycle start pulse to setup.
- `setup_result`, in, `triangle_setup_t`; `setup_done`, in, 1: setup completion.
- `rast_tri`, out, `triangle_setup_t`: registered triangle to the rasterizer; held stable until `rast_done`.
- `rast_start`, out, 1: one-cycle start pulse.
- `rast_done`, in, 1: rasterizer finished.
- `flush`, in, 1: discard all queued and unrasterized work.
- `busy`, out, 1: any work is pending or in flight.
- `stat_clear`, in, 1: zero the statistics counters.
- `stat_accepted`, `stat_culled`, `stat_rasterized`, out, `CNT_WIDTH`: statistics counters.

## Operation
**Input FIFO**
- `tri_ready = (fifo_count != FIFO_DEPTH)`, decoded from registered state only.
- A push happens when `tri_valid && tri_ready`.
- Read and write pointers wrap modulo `FIFO_DEPTH`.

**Setup FSM (SU_IDLE, SU_WAIT)**
- In SU_IDLE, if the FIFO is non-empty and `slot_count < SETUP_SLOTS`, the block does all of the following in the same cycle:
  - pops the FIFO head;
  - registers the head into `setup_v*`;
  - asserts `setup_start` for one cycle;
  - moves to SU_WAIT.
- In SU_WAIT, on `setup_done`:
  - if `setup_result.valid`, the result is written into the slot buffer at the write pointer and `slot_count` increments;
  - otherwise the triangle is culled and nothing is written;
  - the FSM returns to SU_IDLE in both cases.
- The earliest next `setup_start` is the cycle after `setup_done`.
- `setup_done` is ignored in SU_IDLE.

**Raster FSM (RA_IDLE, RA_RUN)**
- In RA_IDLE with `slot_count != 0`:
  - the slot head is copied to `rast_tri`;
  - `rast_start` pulses;
  - the slot is popped;
  - the FSM moves to RA_RUN.
- In RA_RUN, on `rast_done` the FSM returns to RA_IDLE. The next start is no earlier than the following cycle.

**Simultaneous events and boundaries**
- FIFO push and pop in the same cycle: `fifo_count` is unchanged. A push into a full FIFO is impossible because `tri_ready` is low.
- Slot write (`setup_done` with valid) and slot pop in the same cycle: `slot_count` is unchanged.
- Slots cannot overflow. Setup issues only when a slot is free, at most one setup is in flight, and pops only decrement `slot_count`.
- **Flush** takes effect in the cycle `flush` is high:
  - FIFO and slot counts and pointers clear;
  - `tri_ready` is forced low for that cycle;
  - a setup in flight stays in SU_WAIT but its result is discarded (neither counted as culled nor stored);
  - a raster in flight (RA_RUN) runs to `rast_done`.
- `busy = (fifo_count != 0) | (SU_WAIT) | (slot_count != 0) | (RA_RUN)`.
- Reset mid-operation: all state returns to reset values immediately. The external units are reset by the same `rst`.

## Timing
- Reset values: `tri_ready` is 1. The following are all 0: `setup_start`, `rast_start`, `busy`, `setup_v*`, `rast_tri`, all counters.
- A triangle accepted in cycle t can raise `setup_start` in cycle t+1 at the earliest.
- `setup_done` with valid in cycle t can raise `rast_start` in cycle t+1 at the earliest (slot visible the next cycle).
- Steady-state throughput is bounded by max(setup latency+1, raster time+1) per triangle, not their sum.

## Configuration
- `CELERY_TRI_STATS_EN`, when defined:
  - `stat_accepted` increments on each push;
  - `stat_culled` increments on each non-discarded `setup_done` with `!valid`;
  - `stat_rasterized` increments on each `rast_done` in RA_RUN;
  - all three saturate at all-ones;
  - `stat_clear` zeroes them and has priority over increments.
- When undefined: no counter registers; outputs are tied to 0; `stat_clear` is ignored.

## Structure
- `vertex_t` and `triangle_setup_t` are already in `celery_pkg`.
- Add `dispatch_su_state_t` and `dispatch_ra_state_t` to `celery_pkg`.
- One sub-module: `sync_fifo` (parametrised width and depth, with count), instantiated for both the vertex queue and the slot buffer.

## Test plan
- **Overlap:** 3 valid triangles; setup takes 4 cycles, raster 20. Required: second `setup_start` occurs while the first raster is in RA_RUN; `stat_rasterized`=3.
- **Backpressure:** `FIFO_DEPTH`=4, raster held (no `rast_done`), 10 triangles offered. Required: `tri_ready` falls after FIFO 4 + slots 2 + in-flight 1 are occupied; no triangle is lost or duplicated.
- **Cull:** middle of 3 triangles degenerate. Required: `stat_culled`=1, 2 `rast_start` pulses, `rast_tri` matches triangles 1 and 3.
- **Flush:** flush during SU_WAIT with 2 queued, 1 slot full, raster running. Required: running raster completes; no further `rast_start`; `busy` drops the cycle after `rast_done`.
- **Simultaneous:** `setup_done`(valid) and a slot pop in the same cycle with `slot_count`=1. Required: `slot_count` stays 1.
- **Reset:** `rst` asserted mid-stream. Required: all outputs at reset values in the same cycle; counters (if `CELERY_TRI_STATS_EN`) are 0.
